idma_legalizer_req_arbiter: RTL and testbench

- Shares one 1D legalizer between NumReq independent 1D request sources (for example several frontends or midend channels) using round-robin arbitration with a locked grant.
- Records the requester index of every transfer handed to the legalizer in an in-order ID FIFO.
- On each backend completion pulse, routes a one-cycle done back to the owning requester.
- Sits between the frontends/midends and the legalizer's req_i/valid_i/ready_o port.

---
 rtl/idma_legalizer_req_arbiter_pkg.sv | 9 +
 rtl/idma_legalizer_req_arbiter_fifo.sv | 46 ++++
 rtl/idma_legalizer_req_arbiter.sv | 121 ++++++++++++
 tb/tb_idma_legalizer_req_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_legalizer_req_arbiter_pkg.sv
// Helpers shared by the legalizer request arbiter and its ID FIFO.
package idma_legalizer_req_arbiter_pkg;

   // Index width that stays legal (>=1 bit) even for a single entry.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/idma_legalizer_req_arbiter_fifo.sv
// In-order ID FIFO: remembers which requester owns each transfer in flight.
module idma_legalizer_req_arbiter_fifo
   import idma_legalizer_req_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DATA_W = 2
)(
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [DATA_W-1:0]          data_i,
   input  logic                       pop_i,
   output logic [DATA_W-1:0]          data_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned PW = idx_width(DEPTH);
   localparam logic [PW-1:0] LP_LAST = PW'(DEPTH - 1);

   logic [DATA_W-1:0]          r_mem [DEPTH];
   logic [PW-1:0]              r_wptr;
   logic [PW-1:0]              r_rptr;
   logic [$clog2(DEPTH+1)-1:0] r_count;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (push_i) r_wptr <= (r_wptr == LP_LAST) ? '0 : r_wptr + 1'b1;
         if (pop_i)  r_rptr <= (r_rptr == LP_LAST) ? '0 : r_rptr + 1'b1;
         if (push_i && !pop_i)      r_count <= r_count + 1'b1;
         else if (!push_i && pop_i) r_count <= r_count - 1'b1;
      end
   end

   // Storage carries no reset; a push into a full FIFO overwrites the head being popped.
   always_ff @(posedge clk_i) begin
      if (push_i) r_mem[r_wptr] <= data_i;
   end

   assign data_o  = r_mem[r_rptr];
   assign count_o = r_count;

endmodule

// File: rtl/idma_legalizer_req_arbiter.sv
// Round-robin arbiter sharing one 1D legalizer between NumReq sources, with
// locked grants and in-order routing of completion pulses back to the owner.
module idma_legalizer_req_arbiter
   import idma_legalizer_req_arbiter_pkg::*;
#(
   parameter int unsigned NumReq           = 4,
   parameter int unsigned OutstandingDepth = 8,
   parameter type         idma_req_t       = logic
)(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  idma_req_t [NumReq-1:0] req_i,
   input  logic [NumReq-1:0]      valid_i,
   output logic [NumReq-1:0]      ready_o,
   output idma_req_t              req_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   input  logic                   flush_i,
   input  logic                   done_i,
   output logic [NumReq-1:0]      done_o,
   output logic                   busy_o,
   output logic                   err_o
);

   localparam int unsigned IW = idx_width(NumReq);
   localparam int unsigned CW = $clog2(OutstandingDepth + 1);
   localparam logic [IW:0]   LP_NREQ  = (IW+1)'(NumReq);
   localparam logic [IW-1:0] LP_LAST  = IW'(NumReq - 1);
   localparam logic [CW-1:0] LP_DEPTH = CW'(OutstandingDepth);

   logic [IW-1:0]     r_rr;
   logic              r_lock;
   logic [IW-1:0]     r_lock_idx;
   logic [NumReq-1:0] r_done;
   logic              r_err;

   logic [NumReq-1:0] w_rot;
   logic [IW-1:0]     w_ofs;
   logic [IW:0]       w_sum;
   logic              w_found;
   logic [IW-1:0]     w_arb_idx;
   logic [IW-1:0]     w_grant;
   logic              w_have;
   logic              w_room;
   logic              w_allowed;
   logic              w_hs;
   logic              w_pop;
   logic [CW-1:0]     w_count;
   logic [IW-1:0]     w_head;

   // Rotate the valids so that the rr pointer sits at bit 0; the lowest set
   // bit is then the round-robin winner, offset back by the pointer.
   assign w_rot = NumReq'({valid_i, valid_i} >> r_rr);

   always_comb begin
      w_found = 1'b0;
      w_ofs   = '0;
      for (int j = NumReq - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_found = 1'b1;
            w_ofs   = IW'(j);
         end
      end
      w_sum = {1'b0, r_rr} + {1'b0, w_ofs};
      if (w_sum >= LP_NREQ) w_sum = w_sum - LP_NREQ;
      w_arb_idx = w_sum[IW-1:0];
   end

   // A lock always has room: while locked nothing is pushed and count can only fall.
   assign w_pop     = done_i & (w_count != '0);
   assign w_room    = (w_count < LP_DEPTH) | w_pop;
   assign w_allowed = ~rst_i & (r_lock | (~flush_i & w_room));
   assign w_grant   = r_lock ? r_lock_idx : w_arb_idx;
   assign w_have    = r_lock | w_found;

   assign req_o   = req_i[w_grant];
   assign valid_o = w_have & valid_i[w_grant] & w_allowed;
   assign ready_o = (w_have & ready_i & w_allowed) ? (NumReq'(1) << w_grant) : '0;
   assign w_hs    = valid_o & ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rr       <= '0;
         r_lock     <= 1'b0;
         r_lock_idx <= '0;
         r_done     <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_hs) begin
            r_rr   <= (w_grant == LP_LAST) ? '0 : w_grant + 1'b1;
            r_lock <= 1'b0;
         end else if (valid_o) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_grant;
         end
         r_done <= w_pop ? (NumReq'(1) << w_head) : '0;
         if (done_i && (w_count == '0)) r_err <= 1'b1;
      end
   end

   idma_legalizer_req_arbiter_fifo #(
      .DEPTH  (OutstandingDepth),
      .DATA_W (IW)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_hs),
      .data_i  (w_grant),
      .pop_i   (w_pop),
      .data_o  (w_head),
      .count_o (w_count)
   );

   assign done_o = r_done;
   assign err_o  = r_err;
   assign busy_o = r_lock | (w_count != '0);

   // A locked requester must keep its request up until the handshake.
   assert property (@(posedge clk_i) disable iff (rst_i) r_lock |-> valid_i[r_lock_idx]);

endmodule

// File: tb/tb_idma_legalizer_req_arbiter.sv
// Directed and random bench for idma_legalizer_req_arbiter against a queue-based model.
module tb_idma_legalizer_req_arbiter;

   localparam int N = 4;
   localparam int D = 8;
   typedef logic [15:0] req_t;

   logic            clk = 1'b0;
   logic            rst;
   req_t [N-1:0]    req_i;
   logic [N-1:0]    valid_i;
   logic [N-1:0]    ready_o;
   req_t            req_o;
   logic            valid_o;
   logic            ready_i;
   logic            flush_i;
   logic            done_i;
   logic [N-1:0]    done_o;
   logic            busy_o;
   logic            err_o;

   int checks = 0;
   int errors = 0;

   // Reference model state: rr pointer, pending (presented, not taken) request,
   // queue of owners in acceptance order, expected registered outputs.
   int           m_rr;
   bit           m_lock;
   int           m_lidx;
   int           m_q[$];
   logic [N-1:0] m_done;
   bit           m_err;
   bit           e_valid;
   bit           e_hs;
   int           e_g;

   int seq_b[5] = '{0, 1, 2, 3, 0};

   always #5 clk = ~clk;

   idma_legalizer_req_arbiter #(
      .NumReq           (N),
      .OutstandingDepth (D),
      .idma_req_t       (req_t)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .req_i   (req_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .req_o   (req_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .flush_i (flush_i),
      .done_i  (done_i),
      .done_o  (done_o),
      .busy_o  (busy_o),
      .err_o   (err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_rr = 0;
      m_lock = 0;
      m_lidx = 0;
      m_q.delete();
      m_done = '0;
      m_err = 0;
      e_valid = 0;
      e_hs = 0;
      e_g = 0;
   endtask

   // Let inputs settle, predict the combinational outputs and compare everything.
   task automatic settle();
      int c;
      bit found;
      bit room;
      bit allowed;
      logic [N-1:0] exp_rdy;
      #1;
      found = 0;
      e_g = 0;
      if (m_lock) begin
         found = 1;
         e_g = m_lidx;
      end else begin
         for (int k = 0; k < N; k++) begin
            c = (m_rr + k) % N;
            if (!found && valid_i[c]) begin
               found = 1;
               e_g = c;
            end
         end
      end
      room    = (m_q.size() < D) || (done_i && m_q.size() > 0);
      allowed = m_lock || (!flush_i && room);
      e_valid = found && valid_i[e_g] && allowed;
      e_hs    = e_valid && ready_i;
      exp_rdy = '0;
      if (found && ready_i && allowed) exp_rdy[e_g] = 1'b1;
      chk("valid_o", valid_o, e_valid);
      chk("ready_o", ready_o, exp_rdy);
      if (e_valid) chk("req_o", req_o, req_i[e_g]);
      chk("done_o", done_o, m_done);
      chk("err_o", err_o, m_err);
      chk("busy_o", busy_o, (m_lock || m_q.size() != 0));
   endtask

   task automatic advance();
      m_done = '0;
      if (done_i) begin
         if (m_q.size() > 0) m_done[m_q.pop_front()] = 1'b1;
         else m_err = 1;
      end
      if (e_hs) begin
         m_q.push_back(e_g);
         m_rr = (e_g + 1) % N;
         m_lock = 0;
      end else if (e_valid) begin
         m_lock = 1;
         m_lidx = e_g;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      settle();
      advance();
   endtask

   task automatic drain();
      valid_i = '0;
      flush_i = 1'b0;
      for (int g = 0; g < 3 * D && m_q.size() > 0; g++) begin
         done_i = 1'b1;
         cyc();
      end
      done_i = 1'b0;
      cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      req_i = '0;
      valid_i = '1;
      ready_i = 1'b1;
      flush_i = 1'b0;
      done_i = 1'b0;
      #2 rst = 1'b1;
      #10;
      chk("rst_valid_o", valid_o, 1'b0);
      chk("rst_ready_o", ready_o, 4'b0000);
      chk("rst_done_o", done_o, 4'b0000);
      chk("rst_err_o", err_o, 1'b0);
      chk("rst_busy_o", busy_o, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      valid_i = '0;
      model_reset();

      // All four valid from rr 0: grants rotate 0,1,2,3,0.
      valid_i = '1;
      ready_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < N; i++) req_i[i] = {4'hB, 4'(i), 8'(k)};
         settle();
         chk("B_grant", req_o[11:8], seq_b[k]);
         advance();
      end
      drain();

      // Move rr to 2, then only 0 and 3 valid: 3 wins.
      valid_i = 4'b0010;
      req_i[1] = 16'h1111;
      cyc();
      valid_i = 4'b1001;
      req_i[0] = 16'h0A0A;
      req_i[3] = 16'h3333;
      settle();
      chk("B_from_rr2", req_o, 16'h3333);
      advance();
      valid_i[3] = 1'b0;
      cyc();
      drain();

      // Single requester 2, three back-to-back, then three completions.
      valid_i = 4'b0100;
      ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req_i[2] = 16'h2A00 + 16'(k);
         settle();
         chk("A_valid", valid_o, 1'b1);
         chk("A_req", req_o, 16'h2A00 + 16'(k));
         advance();
      end
      valid_i = '0;
      for (int k = 0; k < 3; k++) begin
         done_i = 1'b1;
         cyc();
         chk("A_done", done_o, 4'b0100);
      end
      done_i = 1'b0;
      cyc();
      chk("A_done_end", done_o, 4'b0000);

      // Lock on requester 1 for 5 cycles while 0 waits, then wrap to 0.
      valid_i = 4'b0001;
      req_i[0] = 16'hC000;
      cyc();
      valid_i = 4'b0011;
      req_i[1] = 16'hC111;
      ready_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         settle();
         chk("C_req_held", req_o, 16'hC111);
         chk("C_ready_low", ready_o, 4'b0000);
         advance();
      end
      ready_i = 1'b1;
      settle();
      chk("C_ready_req1", ready_o, 4'b0010);
      advance();
      valid_i[1] = 1'b0;
      settle();
      chk("C_wrap_to_0", req_o, 16'hC000);
      advance();
      drain();

      // Fill all slots, then a pop in the same cycle admits one more.
      valid_i = 4'b1000;
      ready_i = 1'b1;
      for (int k = 0; k < D; k++) begin
         req_i[3] = 16'hD000 + 16'(k);
         cyc();
      end
      req_i[3] = 16'hD0FF;
      settle();
      chk("D_full_blocks", valid_o, 1'b0);
      advance();
      done_i = 1'b1;
      settle();
      chk("D_pop_admits", valid_o, 1'b1);
      advance();
      done_i = 1'b0;
      req_i[3] = 16'hD100;
      settle();
      chk("D_still_full", valid_o, 1'b0);
      advance();
      drain();

      // Flush blocks a fresh grant but not a locked one.
      valid_i = 4'b0001;
      req_i[0] = 16'hE000;
      flush_i = 1'b1;
      settle();
      chk("E_flush_blocks", valid_o, 1'b0);
      advance();
      flush_i = 1'b0;
      ready_i = 1'b0;
      cyc();
      flush_i = 1'b1;
      settle();
      chk("E_locked_presented", valid_o, 1'b1);
      advance();
      ready_i = 1'b1;
      settle();
      chk("E_locked_accepted", ready_o, 4'b0001);
      advance();
      flush_i = 1'b0;
      drain();

      // Random traffic against the model.
      for (int t = 0; t < 600; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!valid_i[i] && $urandom_range(0, 99) < 40) begin
               valid_i[i] = 1'b1;
               req_i[i] = 16'($urandom);
            end
         end
         ready_i = ($urandom_range(0, 99) < 65);
         flush_i = ($urandom_range(0, 99) < 10);
         done_i  = (m_q.size() > 0) && ($urandom_range(0, 99) < 35);
         cyc();
         if (e_hs) valid_i[e_g] = 1'b0;
      end
      flush_i = 1'b0;
      ready_i = 1'b1;
      for (int t = 0; t < 64 && valid_i != '0; t++) begin
         done_i = (m_q.size() > 0);
         cyc();
         if (e_hs) valid_i[e_g] = 1'b0;
      end
      done_i = 1'b0;
      drain();

      // Completion with nothing outstanding sets a sticky error.
      done_i = 1'b1;
      cyc();
      chk("F_err_set", err_o, 1'b1);
      done_i = 1'b0;
      cyc();
      cyc();
      chk("F_err_sticky", err_o, 1'b1);

      // Two transfers, then one completion while a new request locks.
      valid_i = 4'b0010;
      req_i[1] = 16'hF001;
      ready_i = 1'b1;
      cyc();
      cyc();
      valid_i = 4'b0100;
      req_i[2] = 16'hF002;
      ready_i = 1'b0;
      done_i = 1'b1;
      cyc();
      done_i = 1'b0;
      chk("F_pre_done", done_o, 4'b0010);
      chk("F_pre_busy", busy_o, 1'b1);
      rst = 1'b1;
      #1;
      chk("F_rst_valid_o", valid_o, 1'b0);
      chk("F_rst_busy_o", busy_o, 1'b0);
      chk("F_rst_done_o", done_o, 4'b0000);
      chk("F_rst_err_o", err_o, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      valid_i = '0;
      model_reset();
      cyc();
      valid_i = 4'b0001;
      req_i[0] = 16'hF100;
      ready_i = 1'b1;
      settle();
      chk("F_after_rst_grant", req_o, 16'hF100);
      advance();
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
